// File: rtl/board_pkg.sv
// Shared types and helpers for the match-3 board controller slice.
// Coordinates are {row[2:0], col[2:0]} on an 8x8 grid.
package board_pkg;

  localparam int BOARD_DIM = 8;

  typedef logic [2:0] cell_t;
  typedef logic [5:0] coord_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWAP,
    S_DETECT,
    S_CLEAR,
    S_REFRESH,
    S_UNDO
  } seq_state_e;

  // Widened to 4 bits so 7 and 0 are never treated as neighbours.
  function automatic logic is_adjacent(
    input coord_t a,
    input coord_t b
  );
    logic [3:0] ra, ca, rb, cb;
    logic       row_nb, col_nb;
    ra = {1'b0, a[5:3]};
    ca = {1'b0, a[2:0]};
    rb = {1'b0, b[5:3]};
    cb = {1'b0, b[2:0]};
    row_nb = (ra == rb + 4'd1) || (rb == ra + 4'd1);
    col_nb = (ca == cb + 4'd1) || (cb == ca + 4'd1);
    return ((ra == rb) && col_nb) || ((ca == cb) && row_nb);
  endfunction

endpackage

// File: rtl/board_step_sequencer_lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11.
// Holds its value while en is low.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic        fb;

  assign fb = q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= SEED;
    end else if (en) begin
      q_q <= {q_q[14:0], fb};
    end
  end

  assign q = q_q;

endmodule

// File: rtl/board_step_sequencer.sv
// Per-move controller: swap, detect, clear, refresh and cascades,
// with undo of non-scoring swaps, scoring and timeout abort.
module board_step_sequencer
  import board_pkg::*;
#(
  parameter int          MAX_CASCADE = 8,
  parameter int          TIMEOUT     = 1024,
  parameter logic [15:0] SEED_INIT   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        move_valid,
  output logic        move_ready,
  input  coord_t      move_a,
  input  coord_t      move_b,
  output logic        swap_start,
  output coord_t      swap_a,
  output coord_t      swap_b,
  input  logic        swap_done,
  output logic        detect_start,
  input  logic        detect_done,
  input  logic [6:0]  match_count,
  output logic        clear_start,
  input  logic        clear_done,
  output logic        refresh_start,
  input  logic        refresh_done,
  output logic [15:0] rand_seed,
  output logic [15:0] score,
  output logic [3:0]  cascade,
  output logic        move_err,
  output logic        abort,
  output logic        busy
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [3:0]  CASC_MAX = 4'(MAX_CASCADE);

  seq_state_e  state_q, state_d;
  logic        first_q, first_d;
  logic [15:0] tmo_q, tmo_d;
  coord_t      a_q, a_d, b_q, b_d;
  logic [15:0] score_q, score_d;
  logic [3:0]  casc_q, casc_d;
  logic        err_q, err_d;
  logic        abort_q, abort_d;

  logic        live;
  logic [3:0]  mult;
  logic [10:0] prod;
  logic [16:0] sum;

  // Done inputs seen on the start cycle are ignored.
  assign live = !first_q;
  assign mult = casc_q + 4'd1;
  assign prod = {4'b0, match_count} * {7'b0, mult};
  assign sum  = {1'b0, score_q} + {6'b0, prod};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    score_d = score_q;
    casc_d  = casc_q;
    err_d   = 1'b0;
    abort_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (move_valid) begin
          if (is_adjacent(move_a, move_b)) begin
            a_d     = move_a;
            b_d     = move_b;
            casc_d  = 4'd0;
            state_d = S_SWAP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SWAP: begin
        if (live && swap_done) state_d = S_DETECT;
      end
      S_DETECT: begin
        if (live && detect_done) begin
          if (match_count != 7'd0) begin
            score_d = sum[16] ? 16'hFFFF : sum[15:0];
            state_d = S_CLEAR;
          end else if (casc_q == 4'd0) begin
            state_d = S_UNDO;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_CLEAR: begin
        if (live && clear_done) state_d = S_REFRESH;
      end
      S_REFRESH: begin
        if (live && refresh_done) begin
          casc_d = casc_q + 4'd1;
          if (casc_d == CASC_MAX) begin
            abort_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_DETECT;
          end
        end
      end
      S_UNDO: begin
        if (live && swap_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && state_d == state_q &&
        tmo_q == TMO_LAST) begin
      abort_d = 1'b1;
      state_d = S_IDLE;
    end
  end

  assign first_d = (state_d != state_q);
  assign tmo_d   = (first_d || state_q == S_IDLE) ?
                   16'd0 : tmo_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      first_q <= 1'b0;
      tmo_q   <= 16'd0;
      a_q     <= '0;
      b_q     <= '0;
      score_q <= 16'd0;
      casc_q  <= 4'd0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      tmo_q   <= tmo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      score_q <= score_d;
      casc_q  <= casc_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  lfsr16 #(.SEED(SEED_INIT)) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state_q != S_REFRESH),
    .q    (rand_seed)
  );

  assign move_ready    = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign swap_start    = first_q &&
                         (state_q == S_SWAP || state_q == S_UNDO);
  assign detect_start  = first_q && (state_q == S_DETECT);
  assign clear_start   = first_q && (state_q == S_CLEAR);
  assign refresh_start = first_q && (state_q == S_REFRESH);
  assign swap_a        = a_q;
  assign swap_b        = b_q;
  assign score         = score_q;
  assign cascade       = casc_q;
  assign move_err      = err_q;
  assign abort         = abort_q;

endmodule

// File: doc/board_step_sequencer.md
Name: board_step_sequencer

Overview:
- Top-level controller for one player move on the 8x8, 3-bit-cell board.
- Accepts a swap request and checks adjacency. Sequences swap, match-detect, clear, refresh (gravity, column collapse, refill) and any cascades by start/done handshakes to the datapath blocks.
- Undoes non-scoring swaps, accumulates score, and supplies the refill seed to refresh.
- Sits between the input/UI layer and the board datapath.

Parameters:
- MAX_CASCADE, 8, cascade count at which the move is force-terminated.
- TIMEOUT, 1024, cycles to wait for any *_done before aborting.
- SEED_INIT, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- move_valid  in  1  move request; held until move_ready
- move_ready  out  1  high in IDLE only; transfer when valid&&ready
- move_a  in  6  {row[2:0],col[2:0]} first cell
- move_b  in  6  {row[2:0],col[2:0]} second cell
- swap_start  out  1  1-cycle pulse, swap cells held on swap_a/swap_b
- swap_a  out  6  latched cell A
- swap_b  out  6  latched cell B
- swap_done  in  1  swap (or undo) complete
- detect_start  out  1  1-cycle pulse
- detect_done  in  1  detection complete
- match_count  in  7  cells marked for removal; valid with detect_done
- clear_start  out  1  1-cycle pulse
- clear_done  in  1
- refresh_start  out  1  1-cycle pulse
- refresh_done  in  1
- rand_seed  out  16  LFSR value, frozen while in REFRESH
- score  out  16  accumulated score, saturating
- cascade  out  4  cascade index of the current move
- move_err  out  1  1-cycle pulse: illegal move rejected
- abort  out  1  1-cycle pulse: timeout or cascade limit hit
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: state IDLE; all start pulses, move_err, abort = 0; busy = 0; score = 0; cascade = 0; swap_a = swap_b = 0; rand_seed = SEED_INIT.
- Reset mid-move returns to IDLE immediately. No undo is issued.
- States: IDLE, SWAP, DETECT, CLEAR, REFRESH, UNDO.
- IDLE:
  - On handshake, check legality: the two cells are orthogonally adjacent (same row with |dcol|=1, or same col with |drow|=1).
  - Illegal move: move_err pulses next cycle; stay IDLE.
  - Legal move: latch swap_a/swap_b, cascade <= 0, go to SWAP and pulse swap_start on the entry cycle.
- Start rule: every *_start pulses exactly once, on the first cycle in its state. The block then waits for the matching *_done. A *_done arriving in the same cycle as the start is ignored.
- SWAP --swap_done--> DETECT.
- DETECT, on detect_done:
  - match_count != 0 → CLEAR. Score += match_count*(cascade+1), saturating at 16'hFFFF, computed in 16-bit arithmetic.
  - match_count = 0 and cascade = 0 → UNDO.
  - match_count = 0 and cascade > 0 → IDLE.
- CLEAR --clear_done--> REFRESH.
- REFRESH --refresh_done--> cascade += 1.
  - If the new cascade = MAX_CASCADE: abort pulse, → IDLE.
  - Otherwise → DETECT.
- UNDO: pulse swap_start with the same swap_a/swap_b; on swap_done → IDLE. No score change.
- Timeout: one counter, reset on every state entry. Reaching TIMEOUT-1 in any wait state → abort pulse, → IDLE. Score is kept.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle except in REFRESH.
- Stray *_done inputs in IDLE or in a non-matching state are ignored.
- move_valid while busy is not accepted (move_ready = 0). No queueing.
- score and cascade remain readable in IDLE until the next accepted move; cascade clears only on acceptance.

Decomposition:
- Package board_pkg:
  - cell_t (3-bit; 3'd0 = empty, 1..6 colours, 7 reserved)
  - coord_t ({row,col} 6-bit)
  - BOARD_DIM = 8
  - seq_state_e enum
  - function is_adjacent(coord_t, coord_t)
- Sub-module lfsr16 (clk, rst_n, en, seed reset value → q). Shared later with refresh refill.

Test Plan:
- Legal move, one match: move (2,3)↔(2,4); detect_done with match_count=3, then 0 after refresh → score 3, cascade 1, sequence swap→detect→clear→refresh→detect→IDLE, each start pulsed exactly once.
- Non-scoring move: (0,0)↔(1,0), first match_count=0 → UNDO issues second swap_start with swap_a=0,swap_b=8; score unchanged; IDLE.
- Illegal moves: (0,0)↔(1,1) and (3,3)↔(3,3) → move_err pulse each, busy stays 0, no swap_start.
- Cascade scoring and limit: match counts 3,4,5 → score 3+8+15=26. Separately, MAX_CASCADE=2 with continuous matches → abort after second refresh_done, IDLE.
- Timeout and reset: withhold clear_done for TIMEOUT cycles → abort, IDLE. Assert rst_n low mid-REFRESH → all outputs return to reset values asynchronously, score 0, rand_seed=16'hACE1.
- Saturation: preload via repeated moves to score 16'hFFF0, match_count=64 at cascade 0 → score 16'hFFFF.
